// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the Mul_Div sequencer, the Mul_Div unit
// and the decoder.
//   - one-hot operation codes driven on the Mul_Div choice bus
//   - sequencer state encoding
//   - default timeout in RUN cycles
//   - is_onehot() helper used to qualify requests
package muldiv_pkg;

    localparam logic [3:0] OP_DIV   = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0001;

    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer between decode/execute and the multi-cycle Mul_Div unit.
// Accepts MUL/MULTU/DIV/DIVU, launches the unit for one cycle, stalls the CPU
// while it runs and commits q/r into LO/HI. Also services MTHI/MTLO, catches
// divide-by-zero without launching, and aborts a hung unit after TIMEOUT cycles.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-low reset
//   op_valid, op_sel    mul/div request, one-hot op code
//   mthi, mtlo, rs_val  HI/LO writes; rs_val also operand a
//   rt_val              operand b
//   stall               CPU must hold its instruction (state != IDLE)
//   hi, lo              architectural HI/LO registers
//   done                one-cycle completion pulse
//   err                 sticky timeout flag
//   md_choice/md_a/md_b launch interface to Mul_Div
//   md_buzy/md_q/md_r   Mul_Div status and results
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    input  logic [3:0]   op_sel,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    output logic         stall,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         done,
    output logic         err,
    output logic [3:0]   md_choice,
    output logic [W-1:0] md_a,
    output logic [W-1:0] md_b,
    input  logic         md_buzy,
    input  logic [W-1:0] md_q,
    input  logic [W-1:0] md_r
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_nx;
    logic [3:0]    op_r;
    logic [CW-1:0] cnt;

    logic is_div;
    logic accept;   // launch the unit
    logic dz;       // divide-by-zero: answer immediately, HI/LO untouched
    logic commit;   // unit finished, write HI/LO
    logic abort;    // unit hung past the timeout
    logic wr_hi, wr_lo;

    assign is_div = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
    assign stall  = (state != ST_IDLE);

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        dz        = 1'b0;
        commit    = 1'b0;
        abort     = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        md_choice = 4'd0;
        case (state)
            ST_IDLE: begin
                // a request (even a malformed one) takes priority over MTHI/MTLO
                if (op_valid) begin
                    if (is_onehot(op_sel)) begin
                        if (is_div && (rt_val == '0)) begin
                            dz = 1'b1;
                        end else begin
                            accept   = 1'b1;
                            state_nx = ST_ISSUE;
                        end
                    end
                end else begin
                    wr_hi = mthi;
                    wr_lo = mtlo;
                end
            end
            ST_ISSUE: begin
                md_choice = op_r;
                state_nx  = ST_RUN;
            end
            ST_RUN: begin
                if (!md_buzy) begin
                    commit   = 1'b1;
                    state_nx = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    abort    = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            op_r  <= 4'd0;
            md_a  <= '0;
            md_b  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            done  <= commit | dz;
            if (accept) begin
                md_a <= rs_val;
                md_b <= rt_val;
                op_r <= op_sel;
            end
            if (state == ST_ISSUE)
                cnt <= '0;
            else if ((state == ST_RUN) && md_buzy && !abort)
                cnt <= cnt + CW'(1);
            if (abort)
                err <= 1'b1;
            if (commit) begin
                hi <= md_r;
                lo <= md_q;
            end else begin
                if (wr_hi) hi <= rs_val;
                if (wr_lo) lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl. A behavioural Mul_Div
// stand-in (configurable latency, can hang buzy high) drives the unit side.
// Expected HI/LO per completed op are queued at issue; a negedge monitor pops
// them on every done pulse.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         op_valid = 1'b0;
    logic [3:0]   op_sel = 4'd0;
    logic         mthi = 1'b0, mtlo = 1'b0;
    logic [W-1:0] rs_val = '0, rt_val = '0;
    logic         stall, done, err;
    logic [W-1:0] hi, lo, md_a, md_b;
    logic [3:0]   md_choice;
    logic         md_buzy = 1'b0;
    logic [W-1:0] md_q = '0, md_r = '0;

    muldiv_ctrl #(.TIMEOUT(TO), .W(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_sel(op_sel),
        .mthi(mthi), .mtlo(mtlo), .rs_val(rs_val), .rt_val(rt_val),
        .stall(stall), .hi(hi), .lo(lo), .done(done), .err(err),
        .md_choice(md_choice), .md_a(md_a), .md_b(md_b),
        .md_buzy(md_buzy), .md_q(md_q), .md_r(md_r)
    );

    always #5 clk = ~clk;

    // ---------------- Mul_Div stand-in ----------------
    int   lat  = 0;
    logic hang = 1'b0;
    int   ucnt = 0;

    always @(posedge clk) begin
        if (md_choice != 4'd0) begin
            int       ia, ib;
            longint   la, lb, lp;
            logic [63:0] up;
            ia = md_a; ib = md_b;
            md_buzy <= 1'b1;
            ucnt    <= lat;
            case (md_choice)
                OP_MULTU: begin up = {32'd0, md_a} * {32'd0, md_b}; md_r <= up[63:32]; md_q <= up[31:0]; end
                OP_MUL:   begin la = ia; lb = ib; lp = la * lb; md_r <= lp[63:32]; md_q <= lp[31:0]; end
                OP_DIV:   if (ib != 0) begin md_q <= ia / ib; md_r <= ia % ib; end
                OP_DIVU:  if (md_b != 0) begin md_q <= md_a / md_b; md_r <= md_a % md_b; end
                default:  ;
            endcase
        end else if (md_buzy && !hang) begin
            if (ucnt == 0) md_buzy <= 1'b0;
            else           ucnt <= ucnt - 1;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; } exp_t;
    exp_t exq[$];
    logic [W-1:0] exp_hi = '0, exp_lo = '0;
    int compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Architectural effect of a request issued while idle; queues the
    // done-time HI/LO. Returns 0 for a launch, 1 for div-by-zero, 2 if ignored.
    function automatic int model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
        longint la, lb, lp;
        logic [63:0] up;
        exp_t e;
        ia = a; ib = b;
        if (!(op == OP_DIV || op == OP_DIVU || op == OP_MUL || op == OP_MULTU)) return 2;
        if ((op == OP_DIV || op == OP_DIVU) && b == 0) begin
            e.hi = exp_hi; e.lo = exp_lo; exq.push_back(e);
            return 1;
        end
        case (op)
            OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            OP_MUL:   begin la = ia; lb = ib; lp = la * lb; exp_hi = lp[63:32]; exp_lo = lp[31:0]; end
            OP_DIV:   begin exp_lo = ia / ib; exp_hi = ia % ib; end
            default:  begin exp_lo = a / b; exp_hi = a % b; end
        endcase
        e.hi = exp_hi; e.lo = exp_lo; exq.push_back(e);
        return 0;
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            if (exq.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_done: got done=1 expected no pulse");
            end else begin
                exp_t e;
                e = exq.pop_front();
                chk("done_hi", 64'(hi), 64'(e.hi));
                chk("done_lo", 64'(lo), 64'(e.lo));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int n = 0;
        while (stall && n < 300) begin @(negedge clk); n++; end
        if (stall) chk("wait_idle_bound", 64'(stall), 64'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int l);
        int kind;
        lat = l;
        @(negedge clk);
        op_valid = 1'b1; op_sel = op; rs_val = a; rt_val = b;
        kind = model_op(op, a, b);
        @(negedge clk);
        op_valid = 1'b0;
        if (kind == 0) begin
            chk("issue_stall", 64'(stall), 64'd1);
            chk("issue_choice", 64'(md_choice), 64'(op));
            @(negedge clk);
            chk("run_choice", 64'(md_choice), 64'd0);
            wait_idle();
        end else begin
            chk("nolaunch_stall", 64'(stall), 64'd0);
            chk("nolaunch_choice", 64'(md_choice), 64'd0);
            chk("dz_done", 64'(done), (kind == 1) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic mt(input logic h, input logic l, input logic [W-1:0] v);
        @(negedge clk);
        mthi = h; mtlo = l; rs_val = v;
        if (h) exp_hi = v;
        if (l) exp_lo = v;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_hi", 64'(hi), 64'(exp_hi));
        chk("mt_lo", 64'(lo), 64'(exp_lo));
        chk("mt_stall", 64'(stall), 64'd0);
    endtask

    initial begin
        int n;
        logic [3:0] ops [4];
        ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_MUL; ops[3] = OP_MULTU;

        // reset
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_choice", 64'(md_choice), 64'd0);

        // directed
        run_op(OP_MULTU, 32'hFFFF_FFFC, 32'd2, 0);
        chk("multu_hi", 64'(hi), 64'h1);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFF8);
        run_op(OP_DIV,  32'hFFFF_FFFC, 32'd2, 2);
        run_op(OP_MUL,  32'd7, 32'hF, 1);
        run_op(OP_DIVU, 32'd4, 32'd2, 3);

        // divide-by-zero with preloaded HI/LO
        mt(1'b1, 1'b0, 32'h1234);
        mt(1'b0, 1'b1, 32'h5678);
        run_op(OP_DIVU, 32'd5, 32'd0, 0);
        @(negedge clk);
        chk("dz_hi", 64'(hi), 64'h1234);
        chk("dz_lo", 64'(lo), 64'h5678);

        // MTHI while running is ignored; the op's result lands instead
        lat = 6;
        @(negedge clk);
        op_valid = 1'b1; op_sel = OP_MULTU; rs_val = 32'd3; rt_val = 32'd5;
        void'(model_op(OP_MULTU, 32'd3, 32'd5));
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        mthi = 1'b1; rs_val = 32'hAAAA_0000;
        @(negedge clk);
        mthi = 1'b0;
        wait_idle();
        chk("run_mthi_ignored", 64'(hi), 64'd0);
        mt(1'b1, 1'b0, 32'hAAAA_0000);
        mt(1'b1, 1'b1, 32'd5);

        // hung unit -> timeout
        hang = 1'b1;
        @(negedge clk);
        op_valid = 1'b1; op_sel = OP_MUL; rs_val = 32'd1; rt_val = 32'd1;
        @(negedge clk);
        op_valid = 1'b0;
        n = 0;
        while (stall && n < 300) begin n++; @(negedge clk); end
        chk("timeout_stall_cycles", 64'(n), 64'(TO + 1));
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_stall", 64'(stall), 64'd0);
        chk("timeout_hi", 64'(hi), 64'd5);
        chk("timeout_lo", 64'(lo), 64'd5);
        hang = 1'b0;
        repeat (10) @(negedge clk);
        run_op(OP_MUL, 32'd3, 32'd3, 1);
        chk("post_to_lo", 64'(lo), 64'd9);
        chk("post_to_err", 64'(err), 64'd1);

        // randomized
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [W-1:0] a, b;
            r = $urandom_range(0, 9);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) b = $urandom_range(1, 9);
            if (a == 32'h8000_0000) a = 32'd1;
            if (r == 4)
                run_op(($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0110, a, b, 0);
            else if (r == 5)
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
            else
                run_op(ops[$urandom_range(0, 3)], a, b, $urandom_range(0, 4));
            chk("rand_hi", 64'(hi), 64'(exp_hi));
            chk("rand_lo", 64'(lo), 64'(exp_lo));
        end

        // reset during RUN drops the op
        lat = 8;
        @(negedge clk);
        op_valid = 1'b1; op_sel = OP_MUL; rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_hi = '0; exp_lo = '0;
        chk("mrst_hi", 64'(hi), 64'd0);
        chk("mrst_lo", 64'(lo), 64'd0);
        chk("mrst_err", 64'(err), 64'd0);
        chk("mrst_stall", 64'(stall), 64'd0);
        chk("mrst_choice", 64'(md_choice), 64'd0);
        chk("mrst_md_a", 64'(md_a), 64'd0);
        repeat (15) @(negedge clk);
        chk("mrst_hi_late", 64'(hi), 64'd0);
        chk("mrst_lo_late", 64'(lo), 64'd0);
        chk("queue_drained", 64'(exq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
